// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the block-move/fill engine.
// Imported by mem_copy_engine and by anything that drives its op input symbolically.
package mem_copy_pkg;

    localparam int MCE_ADDR_W = 8;
    localparam int MCE_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mce_state_t;

    typedef enum logic {
        OP_COPY,
        OP_FILL
    } mce_op_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time memcpy/memset engine that owns the single data_mem port.
// Idle or done: core signals pass through. Busy: engine drives the port and the core stalls.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = MCE_ADDR_W,
    parameter int DATA_W = MCE_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_din,
    input  logic              core_we,
    output logic [DATA_W-1:0] core_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done
);

    mce_state_t        r_state;
    mce_state_t        w_next_state;
    mce_op_t           r_op;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] r_fill_q;

    assign core_dout = mem_dout;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_op      <= OP_COPY;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_cnt     <= '0;
            r_data_q  <= '0;
            r_fill_q  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op      <= mce_op_t'(op);
                        r_src_ptr <= src_addr;
                        r_dst_ptr <= dst_addr;
                        r_cnt     <= len;
                        r_fill_q  <= fill_val;
                    end
                end
                READ: r_data_q <= mem_dout;
                WRITE: begin
                    // Pointers wrap naturally at the address width.
                    r_src_ptr <= r_src_ptr + ADDR_W'(1);
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    r_cnt     <= r_cnt - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        mem_addr     = core_addr;
        mem_din      = core_din;
        mem_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                mem_we = core_we;
                if (start) begin
                    if (len == '0)
                        w_next_state = DONE;
                    else if (mce_op_t'(op) == OP_COPY)
                        w_next_state = READ;
                    else
                        w_next_state = WRITE;
                end
            end
            READ: begin
                busy         = 1'b1;
                mem_addr     = r_src_ptr;
                w_next_state = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_addr = r_dst_ptr;
                mem_din  = (r_op == OP_COPY) ? r_data_q : r_fill_q;
                mem_we   = 1'b1;
                if (r_cnt == ADDR_W'(1))
                    w_next_state = DONE;
                else if (r_op == OP_COPY)
                    w_next_state = READ;
                else
                    w_next_state = WRITE;
            end
            DONE: begin
                // Address/data follow the core again, but a write is held off for this cycle.
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: engine plus a behavioural data_mem, compared against an
// array-level reference of what memcpy/memset should leave behind.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       start;
    logic       op;
    logic [7:0] src_addr, dst_addr, len, fill_val;
    logic [7:0] core_addr, core_din;
    logic       core_we;
    logic [7:0] core_dout, mem_addr, mem_din, mem_dout;
    logic       mem_we, busy, done;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    // Behavioural data_mem: combinational read, write on posedge.
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    mem_copy_engine dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .op        (op),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .core_addr (core_addr),
        .core_din  (core_din),
        .core_we   (core_we),
        .core_dout (core_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ascending byte moves, later bytes see earlier writes (overlap semantics).
    task automatic ref_op(input logic o, input logic [7:0] s, input logic [7:0] d,
                          input int n, input logic [7:0] f);
        logic [7:0] sp, dp;
        sp = s;
        dp = d;
        for (int i = 0; i < n; i++) begin
            ref_mem[dp] = (o == OP_FILL) ? f : ref_mem[sp];
            sp++;
            dp++;
        end
    endtask

    task automatic compare_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    // Launches one operation from IDLE (caller sits just after a posedge) and
    // watches it to completion. disturb_at >= 1 injects a core write plus a
    // bogus start during that busy cycle.
    task automatic run_op(input string tag, input logic o, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] n, input logic [7:0] f,
                          input int disturb_at);
        int busy_n, we_n, done_c;
        bit found;
        busy_n = 0;
        we_n   = 0;
        done_c = 0;
        found  = 0;
        start = 1'b1; op = o; src_addr = s; dst_addr = d; len = n; fill_val = f;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (c == disturb_at) begin
                core_we = 1'b1; core_addr = 8'h80; core_din = 8'h77;
                start = 1'b1; op = OP_FILL; dst_addr = 8'h80; len = 8'd9; fill_val = 8'h77;
            end else if (c == disturb_at + 1) begin
                core_we = 1'b0; start = 1'b0;
            end
            @(negedge CLK);
            if (busy) busy_n++;
            if (mem_we) we_n++;
            if (done) begin
                done_c = c;
                found  = 1;
            end
            @(posedge CLK); #1;
            if (found) break;
        end
        check({tag, " done_seen"}, found, 1);
        check({tag, " busy_cycles"}, busy_n, (n == 0) ? 0 : ((o == OP_FILL) ? n : 2 * n));
        check({tag, " done_cycle"}, done_c, (n == 0) ? 1 : ((o == OP_FILL) ? n + 1 : 2 * n + 1));
        check({tag, " write_count"}, we_n, n);
        @(negedge CLK);
        check({tag, " done_pulse_end"}, done, 0);
        check({tag, " idle_after"}, busy, 0);
        @(posedge CLK); #1;
        ref_op(o, s, d, n, f);
        compare_mem({tag, " image"});
    endtask

    initial begin
        logic [7:0] orig44, orig80, orig10, rs, rd, rl, rf;
        logic       ro;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[8'h10 + i] = mem[8'h10 + i];
        end
        orig44 = mem[8'h44];
        orig80 = mem[8'h80];

        RST_N = 1'b0; start = 1'b0; op = OP_COPY; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0; core_addr = 8'h33; core_din = 8'h00; core_we = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mem_we", mem_we, 0);
        check("reset passthrough addr", mem_addr, 8'h33);

        // 1: basic COPY
        run_op("copy4", OP_COPY, 8'h10, 8'h40, 8'd4, 8'h00, -1);
        check("copy4 mem40", mem[8'h40], 8'h11);
        check("copy4 mem41", mem[8'h41], 8'h22);
        check("copy4 mem42", mem[8'h42], 8'h33);
        check("copy4 mem43", mem[8'h43], 8'h44);
        check("copy4 mem44 untouched", mem[8'h44], orig44);

        // 2: FILL across the address wrap
        run_op("fill_wrap", OP_FILL, 8'h00, 8'hFE, 8'd3, 8'hA5, -1);
        check("fill mem FE", mem[8'hFE], 8'hA5);
        check("fill mem FF", mem[8'hFF], 8'hA5);
        check("fill mem 00", mem[8'h00], 8'hA5);

        // 3: zero-length is a no-op that still pulses done
        run_op("len0", OP_COPY, 8'h10, 8'h90, 8'd0, 8'h00, -1);

        // 4: core write and second start during a copy are ignored
        run_op("copy_disturbed", OP_COPY, 8'h10, 8'h48, 8'd4, 8'h00, 3);
        check("disturbed mem80 untouched", mem[8'h80], orig80);
        check("disturbed mem4B", mem[8'h4B], 8'h44);

        // 5: reset sampled at the edge that would enter the third WRITE
        start = 1'b1; op = OP_COPY; src_addr = 8'h10; dst_addr = 8'h60; len = 8'd6;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("abort busy before reset", busy, 1);
        check("abort in READ mem_we", mem_we, 0);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        check("abort busy after", busy, 0);
        check("abort done after", done, 0);
        check("abort mem_we after", mem_we, 0);
        ref_op(OP_COPY, 8'h10, 8'h60, 2, 8'h00);
        @(posedge CLK); #1;
        check("abort no late done", done, 0);
        compare_mem("abort image");

        // 6: idle passthrough with combinational read-back
        core_addr = 8'h2A; core_din = 8'h21; core_we = 1'b1;
        #1;
        check("passthrough mem_we", mem_we, 1);
        @(posedge CLK); #1;
        core_we = 1'b0;
        ref_mem[8'h2A] = 8'h21;
        #1;
        check("passthrough readback", core_dout, 8'h21);
        core_addr = 8'h41;
        #1;
        check("passthrough comb read", core_dout, ref_mem[8'h41]);
        @(posedge CLK); #1;

        // Overlapping copy with dst > src: source byte propagates forward
        orig10 = ref_mem[8'h10];
        run_op("overlap", OP_COPY, 8'h10, 8'h11, 8'd4, 8'h00, -1);
        check("overlap mem14", mem[8'h14], orig10);

        // Randomized operations against the reference
        for (int k = 0; k < 8; k++) begin
            ro = 1'($urandom);
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 8'($urandom_range(1, 24));
            rf = 8'($urandom);
            run_op($sformatf("rand%0d", k), ro, rs, rd, rl, rf, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
